// File: rtl/encoder_tuner.sv
// encoder_tuner
//   Front-panel rotary encoder front end for the frequency-change path.
//   enc_a/enc_b are synchronized (2-FF), debounced per channel, Gray-decoded
//   into +/-1 quadrature steps, grouped into detents and accumulated into a
//   saturating signed 8-bit delta. A read strobe snapshots the delta onto
//   fq_change and restarts the accumulator.
//
// Ports
//   aclk            system clock
//   aresetn         async active-low reset (deassertion synchronized inside)
//   enc_a, enc_b    encoder channels, asynchronous to aclk
//   fq_read_enable  snapshot-and-clear strobe (one read per high cycle)
//   fq_change       signed delta snapshot, stable between reads
//   fq_change_valid registered (accumulator != 0)
//   enc_error       sticky: both channels changed in the same cycle
//
// Optional feature macro: ENCODER_TUNER_ACCEL_EN
//   When defined, a detent arriving within FAST_CYCLES of the previous one
//   adds +/-4 instead of +/-1 (the first detent after reset is always +/-1).
module encoder_tuner #(
   parameter int DEBOUNCE_CYCLES  = 1000,
   parameter int STEPS_PER_DETENT = 4,
   parameter int FAST_CYCLES      = 200000
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       fq_read_enable,
   output logic [7:0] fq_change,
   output logic       fq_change_valid,
   output logic       enc_error
);

   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] CNT_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic signed [3:0] SPD = 4'(STEPS_PER_DETENT);

   if (DEBOUNCE_CYCLES < 1 || FAST_CYCLES < 1 ||
       !(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4)) begin : g_param_check
      $error("encoder_tuner: illegal parameter value");
   end

   // Gray code 00,01,11,10 -> position 0,1,2,3
   function automatic logic [1:0] gray_pos(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   // ---------------- reset synchronizer ----------------
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rst_sync_q <= '0;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   // ---------------- state ----------------
   logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;   // {a,b}
   logic [1:0]            stable_q, stable_d, prev_q, prev_d;
   logic [1:0][DBW-1:0]   cnt_q, cnt_d;
   logic [1:0]            init_q, init_d;
   logic signed [3:0]     sub_q, sub_d;
   logic signed [7:0]     acc_q, acc_d;
   logic [7:0]            fq_change_q, fq_change_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;

   logic                  init_done;
   logic [1:0]            pos_diff;
   logic                  step_up, step_dn, illegal, det_up, det_dn;
   logic signed [9:0]     mag, incr, sum;
   logic signed [7:0]     acc_sat;

`ifdef ENCODER_TUNER_ACCEL_EN
   localparam int TW = $clog2(FAST_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          seen_q, seen_d;
`endif

   assign init_done = (init_q == 2'd3);

   always_comb begin
      sync1_d     = {enc_a, enc_b};
      sync2_d     = sync1_q;
      stable_d    = stable_q;
      prev_d      = stable_q;
      cnt_d       = cnt_q;
      init_d      = init_q;
      sub_d       = sub_q;
      det_up      = 1'b0;
      det_dn      = 1'b0;
      fq_change_d = fq_change_q;

      // Until the synchronizer has filled with the real pin level, the
      // stable/prev pair simply tracks it, so coming out of reset never
      // produces a step regardless of the encoder position.
      if (!init_done) begin
         init_d   = init_q + 2'd1;
         stable_d = sync2_q;
         prev_d   = sync2_q;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] != stable_q[ch]) begin
               if (cnt_q[ch] == CNT_LAST) begin
                  stable_d[ch] = sync2_q[ch];
                  cnt_d[ch]    = '0;
               end else begin
                  cnt_d[ch] = cnt_q[ch] + 1'b1;
               end
            end else begin
               cnt_d[ch] = '0;
            end
         end
      end

      // Decode compares the stable pair against its one-cycle-old copy.
      pos_diff = gray_pos(stable_q) - gray_pos(prev_q);
      step_up  = init_done && (pos_diff == 2'd1);
      step_dn  = init_done && (pos_diff == 2'd3);
      illegal  = init_done && (pos_diff == 2'd2);

      if (step_up) begin
         if (sub_q + 4'sd1 == SPD) begin
            sub_d  = '0;
            det_up = 1'b1;
         end else begin
            sub_d = sub_q + 4'sd1;
         end
      end else if (step_dn) begin
         if (sub_q - 4'sd1 == -SPD) begin
            sub_d  = '0;
            det_dn = 1'b1;
         end else begin
            sub_d = sub_q - 4'sd1;
         end
      end

`ifdef ENCODER_TUNER_ACCEL_EN
      mag     = (seen_q && (timer_q < TW'(FAST_CYCLES))) ? 10'sd4 : 10'sd1;
      seen_d  = seen_q | det_up | det_dn;
      timer_d = (det_up || det_dn)              ? '0      :
                (timer_q == TW'(FAST_CYCLES))   ? timer_q : timer_q + 1'b1;
`else
      mag = 10'sd1;
`endif

      incr = det_up ? mag : (det_dn ? -mag : 10'sd0);
      sum  = $signed({{2{acc_q[7]}}, acc_q}) + incr;
      if (sum > 10'sd127)       acc_sat = 8'sd127;
      else if (sum < -10'sd128) acc_sat = -8'sd128;
      else                      acc_sat = sum[7:0];

      // A detent landing on the read cycle starts the fresh accumulator.
      if (fq_read_enable) begin
         fq_change_d = acc_q;
         acc_d       = incr[7:0];
      end else begin
         acc_d = acc_sat;
      end

      valid_d = (acc_q != 8'sd0);
      err_d   = err_q | illegal;
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         prev_q      <= '0;
         cnt_q       <= '0;
         init_q      <= '0;
         sub_q       <= '0;
         acc_q       <= '0;
         fq_change_q <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
`ifdef ENCODER_TUNER_ACCEL_EN
         timer_q     <= '0;
         seen_q      <= 1'b0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         init_q      <= init_d;
         sub_q       <= sub_d;
         acc_q       <= acc_d;
         fq_change_q <= fq_change_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
`ifdef ENCODER_TUNER_ACCEL_EN
         timer_q     <= timer_d;
         seen_q      <= seen_d;
`endif
      end
   end

   assign fq_change       = fq_change_q;
   assign fq_change_valid = valid_q;
   assign enc_error       = err_q;

endmodule

// File: tb/tb_encoder_tuner.sv
// Bench for encoder_tuner: directed table, hand-written corner sequences and
// randomized rotation checked against a detent/accumulator reference model.
module tb_encoder_tuner;

   localparam int D    = 4;
   localparam int S    = 4;
   localparam int FAST = 100;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       enc_a = 1'b0;
   logic       enc_b = 1'b0;
   logic       fq_read_enable = 1'b0;
   logic [7:0] fq_change;
   logic       fq_change_valid;
   logic       enc_error;

   encoder_tuner #(
      .DEBOUNCE_CYCLES (D),
      .STEPS_PER_DETENT(S),
      .FAST_CYCLES     (FAST)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .enc_a          (enc_a),
      .enc_b          (enc_b),
      .fq_read_enable (fq_read_enable),
      .fq_change      (fq_change),
      .fq_change_valid(fq_change_valid),
      .enc_error      (enc_error)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // reference model: encoder position, sub-step, accumulator, last detent time
   int m_pos = 0, m_sub = 0, m_acc = 0, m_last_det = -1, m_last_read = 0;
   bit m_err = 0;

   typedef struct {
      int steps;   // signed count of Gray steps (negative = CCW)
      int hold;
      int exp;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string nm, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge aclk);
   endtask

   function automatic logic [1:0] gray(input int p);
      logic [1:0] lut [4];
      lut = '{2'b00, 2'b01, 2'b11, 2'b10};
      return lut[p & 3];
   endfunction

   task automatic model_step(input int dir);
      int d, mag;
      m_sub += dir;
      if (m_sub == S || m_sub == -S) begin
         d     = (m_sub > 0) ? 1 : -1;
         m_sub = 0;
         mag   = 1;
`ifdef ENCODER_TUNER_ACCEL_EN
         if (m_last_det >= 0 && (cyc - m_last_det) <= FAST) mag = 4;
`endif
         m_last_det = cyc;
         m_acc += d * mag;
         if (m_acc > 127)  m_acc = 127;
         if (m_acc < -128) m_acc = -128;
      end
   endtask

   task automatic step(input int dir, input int hold);
      m_pos = (m_pos + dir) & 3;
      {enc_a, enc_b} = gray(m_pos);
      model_step(dir);
      wait_cyc(hold);
   endtask

   task automatic settle_check(input string nm);
      wait_cyc(D + 6);
      check({nm, "_valid"}, fq_change_valid, (m_acc != 0));
      check({nm, "_err"}, enc_error, m_err);
   endtask

   task automatic do_read(input string nm, input int exp);
      check({nm, "_held"}, $signed(fq_change), m_last_read);
      fq_read_enable = 1'b1;
      wait_cyc(1);
      fq_read_enable = 1'b0;
      check(nm, $signed(fq_change), exp);
      m_last_read = exp;
      m_acc = 0;
      wait_cyc(1);
      check({nm, "_vdrop"}, fq_change_valid, 0);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      wait_cyc(2);
      check("rst_chg", $signed(fq_change), 0);
      check("rst_err", enc_error, 0);
      aresetn = 1'b1;
      m_sub = 0; m_acc = 0; m_last_det = -1; m_last_read = 0; m_err = 0;
      wait_cyc(8);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{12, 30, 3};
      tbl[1] = '{-8, 30, -2};
      tbl[2] = '{3, 30, 0};
      tbl[3] = '{1, 30, 1};
      tbl[4] = '{-6, 30, -1};
      tbl[5] = '{2, 30, 0};
      tbl[6] = '{4, 30, 1};

      // ---- reset / idle ----
      wait_cyc(3);
      check("inrst_chg", $signed(fq_change), 0);
      check("inrst_valid", fq_change_valid, 0);
      check("inrst_err", enc_error, 0);
      aresetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         wait_cyc(1);
         if (i % 5 == 4) begin
            check("idle_chg", $signed(fq_change), 0);
            check("idle_valid", fq_change_valid, 0);
            check("idle_err", enc_error, 0);
         end
      end

      // ---- CW rotation: 3 detents ----
      for (int k = 0; k < 12; k++) begin
         step(1, 10);
         if (k == 3) check("cw_valid_first", fq_change_valid, 1);
      end
      settle_check("cw");
`ifdef ENCODER_TUNER_ACCEL_EN
      do_read("cw_read", 9);
`else
      do_read("cw_read", 3);
`endif

      // ---- directed table ----
      for (int v = 0; v < 7; v++) begin
         for (int k = 0; k < (tbl[v].steps < 0 ? -tbl[v].steps : tbl[v].steps); k++)
            step(tbl[v].steps < 0 ? -1 : 1, tbl[v].hold);
         settle_check($sformatf("tbl%0d", v));
         do_read($sformatf("tbl%0d_read", v), tbl[v].exp);
      end

      // ---- glitch rejection ----
      enc_a = 1'b1; wait_cyc(2); enc_a = 1'b0; wait_cyc(10);
      check("glitch2_valid", fq_change_valid, 0);
      step(1, 6);        // accepted forward step, sub-step +1
      step(-1, 10);      // and back, sub-step 0
      check("glitch6_valid", fq_change_valid, 0);
      for (int k = 0; k < 3; k++) step(1, 10);
      check("glitch_sub3_valid", fq_change_valid, 0);
      step(1, 10);
      check("glitch_sub4_valid", fq_change_valid, 1);
      settle_check("glitch");
      do_read("glitch_read", m_acc);

      // ---- saturation, then read coinciding with a detent ----
      for (int k = 0; k < 560; k++) step(-1, 6);
      settle_check("sat");
      do_read("sat_read", -128);
      wait_cyc(120);
      for (int k = 0; k < 3; k++) step(-1, 40);
      m_pos = (m_pos - 1) & 3;
      {enc_a, enc_b} = gray(m_pos);
      model_step(-1);
      wait_cyc(D + 2);           // detent lands on the next edge
      fq_read_enable = 1'b1;
      wait_cyc(1);
      fq_read_enable = 1'b0;
      check("simul_read_old", $signed(fq_change), 0);
      m_last_read = 0;
      wait_cyc(1);
      check("simul_valid", fq_change_valid, 1);
      settle_check("simul");
      do_read("simul_carry", -1);

      // ---- illegal transition 00 -> 11 ----
      {enc_a, enc_b} = 2'b11;
      m_pos = 2;
      m_err = 1;
      settle_check("illegal");
      step(1, 10);
      step(1, 10);
      settle_check("illegal_sticky");
      do_read("illegal_read", m_acc);
      do_reset();
      check("illegal_cleared", enc_error, 0);

`ifdef ENCODER_TUNER_ACCEL_EN
      // ---- acceleration: gaps 50, 300, 300 -> +1 +4 +1 +1 ----
      for (int k = 0; k < 16; k++)
         step(1, (k < 3) ? 10 : (k == 3) ? 14 : (k < 7) ? 12 : (k < 15) ? 75 : 10);
      settle_check("accel");
      do_read("accel_read", 7);
`endif

      // ---- randomized rotation with glitches ----
      for (int k = 0; k < 200; k++) begin
         int dir;
         dir = ($urandom_range(0, 99) < 65) ? 1 : -1;
         if ((k / 50) % 2 == 1) dir = -dir;
         step(dir, $urandom_range(D + 2, D + 10));
         if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
            wait_cyc($urandom_range(1, D - 1));
            {enc_a, enc_b} = gray(m_pos);
            wait_cyc(D + 2);
         end
         if ($urandom_range(0, 11) == 0) begin
            settle_check("rnd");
            do_read("rnd_read", m_acc);
         end
      end
      settle_check("rnd_end");
      do_read("rnd_final", m_acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
